// File: rtl/adpll_ref_gen.sv
// Square-wave reference generator for the adpll RF input: programmable half-period, phase offset, toggle limit, live retune.
// Optional interval jitter from an LFSR when RFGEN_JITTER_EN is defined.
module adpll_ref_gen #(
  parameter int W  = 16,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic [W-1:0]  i_half_period,
  input  logic [W-1:0]  i_phase,
  input  logic [CW-1:0] i_num_toggles,
  input  logic          i_load,
  output logic          o_load_ack,
  output logic          o_rf,
  output logic          o_busy,
  output logic          o_done,
  output logic [CW-1:0] o_toggle_cnt
);

  typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;

  localparam logic [W:0]    ONE     = {{W{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_q;
  logic [W:0]    cnt_q;
  logic [W:0]    ivl_q;
  logic [W-1:0]  h_q;
  logic [W-1:0]  shadow_q;
  logic          pend_q;
  logic [CW-1:0] n_q;
  logic [CW-1:0] tcnt_q;
  logic          rf_q;
  logic          busy_q;
  logic          done_q;
  logic          ack_q;

  logic [1:0]    jb_q;
  logic [1:0]    jb_d;
  logic          tog_d;
  logic [W-1:0]  h_act_d;
  logic [W:0]    start_ivl_d;
  logic [W:0]    run_ivl_d;
  logic [CW-1:0] tcnt_d;

  // Effective interval: 0 behaves as 1, jitter of +/-1 never drives it below 1.
  function automatic logic [W:0] interval(input logic [W-1:0] h, input logic [1:0] jb);
    logic [W:0] v;
    v = (h == '0) ? ONE : {1'b0, h};
    if (jb == 2'b01)
      v = v + ONE;
    else if (jb == 2'b10 && v > ONE)
      v = v - ONE;
    return v;
  endfunction

  assign tog_d       = (state_q != IDLE) && !i_stop && (cnt_q == ONE);
  assign h_act_d     = pend_q ? shadow_q : h_q;
  assign start_ivl_d = interval(i_half_period, jb_q);
  assign run_ivl_d   = interval(h_act_d, jb_d);
  assign tcnt_d      = tcnt_q + CNT_ONE;

`ifdef RFGEN_JITTER_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign jb_q   = lfsr_q[1:0];
  assign jb_d   = lfsr_d[1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      lfsr_q <= 16'hACE1;
    else if (tog_d)
      lfsr_q <= lfsr_d;
  end
`else
  assign jb_q = 2'b00;
  assign jb_d = 2'b00;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ivl_q    <= '0;
      h_q      <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      n_q      <= '0;
      tcnt_q   <= '0;
      rf_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start && !i_stop) begin
            // Delay and first interval are folded into one countdown.
            h_q     <= i_half_period;
            n_q     <= i_num_toggles;
            ivl_q   <= start_ivl_d;
            cnt_q   <= {1'b0, i_phase} + start_ivl_d;
            tcnt_q  <= '0;
            rf_q    <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= DELAY;
          end
        end
        default: begin
          if (i_stop) begin
            rf_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            if (state_q == DELAY && cnt_q <= ivl_q + ONE)
              state_q <= RUN;
            if (tog_d) begin
              rf_q   <= ~rf_q;
              tcnt_q <= tcnt_d;
              if (n_q != '0 && tcnt_d == n_q) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                if (pend_q) begin
                  h_q    <= shadow_q;
                  pend_q <= 1'b0;
                  ack_q  <= 1'b1;
                end
                cnt_q <= run_ivl_d;
              end
            end else begin
              cnt_q <= cnt_q - ONE;
            end
            // A load on a toggle edge lands after the toggle consumed the old shadow.
            if (i_load) begin
              shadow_q <= i_half_period;
              pend_q   <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign o_rf         = rf_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_load_ack   = ack_q;
  assign o_toggle_cnt = tcnt_q;

endmodule

// File: doc/adpll_ref_gen.md
Name: adpll_ref_gen

Overview:
Synthesizable reference-signal generator that drives the RF input of the adpll block. It produces a square wave with a programmable half-period and an initial phase offset, both counted in system-clock cycles. It can emit a fixed number of toggles, and its period can be retuned on the fly so loop tracking can be exercised. It sits beside adpll on the same 50 MHz clock domain and is used on-chip for self-test and in benches as the stimulus source.

Parameters:
W, 16, width of half-period and phase-offset counters (cycles)
CW, 16, width of toggle-count limit and toggle counter

Ports:
i_clk  in  1  system clock (50 MHz nominal)
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  start request; sampled in IDLE only
i_stop  in  1  abort request; effective in DELAY/RUN
i_half_period  in  W  half-period H in cycles; 0 treated as 1
i_phase  in  W  initial phase offset P in cycles
i_num_toggles  in  CW  toggle limit N; 0 = run until stopped
i_load  in  1  one-cycle pulse: shadow i_half_period for retune
o_load_ack  out  1  one-cycle pulse when shadowed H takes effect
o_rf  out  1  generated reference, registered
o_busy  out  1  high in DELAY or RUN
o_done  out  1  one-cycle pulse when N toggles completed
o_toggle_cnt  out  CW  toggles emitted since last start

Behaviour:
- Reset (async, any state): state=IDLE; o_rf=0, o_busy=0, o_done=0, o_load_ack=0, o_toggle_cnt=0; shadow H and pending flag cleared.
- FSM: IDLE -> DELAY -> RUN -> IDLE.
- IDLE:
  - On the edge where i_start=1 and i_stop=0: latch H, P, N; clear o_toggle_cnt; go to DELAY with o_busy=1 from that edge.
  - i_start and i_stop high together: stop wins, remain IDLE.
  - i_load is ignored in IDLE.
- DELAY: waits P cycles (P=0 passes through in one cycle), then enters RUN.
- Toggle timing: the first o_rf toggle occurs exactly P+H clock edges after the start-sampling edge. Later toggles occur every H edges. o_rf starts at 0.
- Each toggle increments o_toggle_cnt, wrapping modulo 2^CW.
- Limit reached (N!=0, Nth toggle): on that same edge go to IDLE, o_busy=0, o_done=1 for one cycle. o_rf keeps its last level.
- i_stop in DELAY/RUN: next edge go to IDLE, o_rf=0, o_busy=0, no o_done.
- i_stop coinciding with the Nth toggle: stop wins, no o_done.
- Retune:
  - i_load in DELAY/RUN captures i_half_period into the shadow register and sets pending.
  - At the next toggle, the following interval uses the new H, pending clears, and o_load_ack pulses on that edge.
  - Multiple i_load pulses before the toggle: latest value wins, single ack.
  - i_load on the same edge as a toggle: applies from the next toggle after that one.
- Counter width: internal interval counter is W+1 bits. No overflow for H, P up to 2^W-1.

Optional Feature:
RFGEN_JITTER_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1, reset to seed) advances once per toggle.
- Each interval is H+j, where j=+1 if lfsr[1:0]=01, -1 if 10, otherwise 0. The result is clamped to a minimum of 1.
- The DELAY interval is unaffected.
- Not defined: intervals are exactly H; no LFSR logic is present.

Test Plan:
- Reset held 500 ns, then released with no start -> o_rf=0, o_busy=0, all outputs static.
- H=32, P=12, N=200, start at t0:
  - first toggle at t0+44 cycles, then every 32 cycles;
  - o_done pulses once at the 200th toggle (t0+12+6400 cycles);
  - o_toggle_cnt=200, o_rf=0, o_busy=0.
- N=0, H=5, P=0; i_stop after 23 toggles -> IDLE on next edge, o_rf=0, no o_done, o_toggle_cnt=23.
- Running H=32:
  - i_load with 40 mid-interval -> next interval 32, then o_load_ack pulses at that toggle, subsequent intervals 40;
  - two loads (40, then 48) before the toggle -> only 48 applied, one ack.
- i_half_period=0, P=0, N=4 -> o_rf toggles every cycle for 4 edges; o_done pulses with the 4th toggle.
- Assert i_rst in RUN mid-interval -> all outputs zero immediately (asynchronous). After release, a start with H=8, P=0 gives first toggle at 8 cycles.
